// File: rtl/part_err_sweep_if.sv
// Handshake/data bundle for the exhaustive partition error sweep.
// master: controller + partition netlists; slave: sweep engine.
interface part_err_sweep_if #(
  parameter int N_IN  = 11,
  parameter int CNT_W = N_IN + 1
) ();
  logic             start;
  logic             abort;
  logic             hold;
  logic [CNT_W-1:0] thresh;
  logic [N_IN-1:0]  vec_out;
  logic             exact_f;
  logic             approx_f;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;
  logic             pass;

  modport master (
    output start, abort, hold, thresh,
    output exact_f, approx_f,
    input  vec_out, busy, done,
    input  err_cnt, pass
  );

  modport slave (
    input  start, abort, hold, thresh,
    input  exact_f, approx_f,
    output vec_out, busy, done,
    output err_cnt, pass
  );
endinterface

// File: rtl/part_err_sweep.sv
// Exhaustive sweep of all 2^N_IN vectors comparing exact vs approximate
// partition outputs; ports: clk, rst_n, bus (slave modport, see _if).
module part_err_sweep #(
  parameter int N_IN  = 11,
  parameter int CNT_W = N_IN + 1
) (
  input logic             clk,
  input logic             rst_n,
  part_err_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [N_IN-1:0]  VEC_MAX = '1;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [N_IN-1:0]  vec_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] err_inc;
  logic             pass_q;
  logic             flag_q;
  logic             fv_q;
  logic             cnt_en;
  logic             mism;

  assign mism = bus.exact_f ^ bus.approx_f;

  // Flag captured one edge earlier is counted at the following edge;
  // the counter saturates rather than wrapping.
  assign cnt_en  = fv_q & flag_q & (err_q != ERR_MAX);
  assign err_inc = err_q + {{(CNT_W-1){1'b0}}, cnt_en};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.abort)
          state_d = IDLE;
        else if (!bus.hold && vec_q == VEC_MAX)
          state_d = DRAIN;
      end
      DRAIN: begin
        state_d = bus.abort ? IDLE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      thr_q   <= '0;
      pass_q  <= 1'b0;
      flag_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            vec_q  <= '0;
            err_q  <= '0;
            thr_q  <= bus.thresh;
            pass_q <= 1'b0;
            flag_q <= 1'b0;
            fv_q   <= 1'b0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            pass_q <= 1'b0;
            fv_q   <= 1'b0;
          end else begin
            err_q <= err_inc;
            if (bus.hold) begin
              fv_q <= 1'b0;
            end else begin
              flag_q <= mism;
              fv_q   <= 1'b1;
              // Last vector stays on the bus while DRAIN counts it.
              if (vec_q != VEC_MAX) vec_q <= vec_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          fv_q <= 1'b0;
          if (bus.abort) begin
            pass_q <= 1'b0;
          end else begin
            err_q  <= err_inc;
            pass_q <= (err_inc <= thr_q);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.vec_out = vec_q;
  assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;

endmodule

// File: tb/tb_part_err_sweep.sv
// Self-checking bench for part_err_sweep: spec vector table, abort/reset
// sequences and random mismatch maps against a counting model.
module tb_part_err_sweep;

  localparam int N  = 11;
  localparam int CW = 12;
  localparam int NV = 1 << N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  part_err_sweep_if #(.N_IN(N), .CNT_W(CW)) bus ();

  part_err_sweep #(.N_IN(N), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  bit mtab [NV];
  logic mm;

  // Partition models: exact is a parity tap; approx differs where the
  // selected mismatch map says so.
  always_comb begin
    mm = 1'b0;
    case (mode)
      1: mm = 1'b1;
      2: mm = (bus.vec_out == 11'h7FF);
      3: mm = (bus.vec_out == 11'h000);
      4: mm = mtab[bus.vec_out];
      default: mm = 1'b0;
    endcase
    bus.exact_f  = ^(bus.vec_out & 11'h5A3);
    bus.approx_f = (^(bus.vec_out & 11'h5A3)) ^ mm;
  end

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_vec(int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * NV; i++) begin
      if (bus.vec_out == v[N-1:0] && bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic start_sweep(int thr, bit with_abort);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.abort  = with_abort;
    bus.thresh = thr[CW-1:0];
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic run_check(string nm, int thr, int hold_at,
                           int hold_len, bit sa, int exp_err,
                           bit exp_pass, int exp_lat);
    int lat;
    int hleft;
    bit h;
    bit frozen;
    bit to;
    logic pass_d;
    start_sweep(thr, sa);
    chk({nm, "_busy0"}, bus.busy, 1);
    chk({nm, "_vec0"}, bus.vec_out, 0);
    lat = 0;
    hleft = hold_len;
    frozen = 1'b1;
    to = 1'b0;
    while (!bus.done) begin
      if (lat > 3 * NV) begin
        to = 1'b1;
        break;
      end
      h = (hleft > 0) && bus.busy && (bus.vec_out == hold_at);
      bus.hold = h;
      if (h) hleft--;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (h && bus.vec_out != hold_at) frozen = 1'b0;
    end
    bus.hold = 1'b0;
    chk({nm, "_timeout"}, to, 0);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_err"}, bus.err_cnt, exp_err);
    chk({nm, "_pass"}, bus.pass, exp_pass);
    chk({nm, "_busy_done"}, bus.busy, 0);
    if (hold_len > 0) chk({nm, "_frozen"}, frozen, 1);
    pass_d = bus.pass;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_pulse"}, bus.done, 0);
    chk({nm, "_pass_hold"}, bus.pass, pass_d);
  endtask

  typedef struct {
    int mode;
    int thr;
    int hold_at;
    int hold_len;
    int exp_err;
    bit exp_pass;
    int exp_lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bit ok;
    bit seen;
    int exp;
    int thr;
    int hl;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold = 1'b0;
    bus.thresh = '0;

    #1;
    chk("rst_vec", bus.vec_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_cnt, 0);
    chk("rst_pass", bus.pass, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{0, 0,    -1,    0, 0,    1'b1, 2049};
    tbl[1] = '{1, 2047, -1,    0, 2048, 1'b0, 2049};
    tbl[2] = '{1, 2048, -1,    0, 2048, 1'b1, 2049};
    tbl[3] = '{2, 0,    -1,    0, 1,    1'b0, 2049};
    tbl[4] = '{3, 1,    -1,    0, 1,    1'b1, 2049};
    tbl[5] = '{1, 2048, 'h100, 5, 2048, 1'b1, 2054};
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      run_check($sformatf("tbl%0d", i), tbl[i].thr, tbl[i].hold_at,
                tbl[i].hold_len, 1'b0, tbl[i].exp_err,
                tbl[i].exp_pass, tbl[i].exp_lat);
    end

    // Abort mid-run, with a stray start while busy.
    mode = 1;
    start_sweep(100, 1'b0);
    wait_vec('h50, ok);
    chk("ab_reach50", ok, 1);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_start_ign", bus.vec_out, 'h51);
    wait_vec('h200, ok);
    chk("ab_reach200", ok, 1);
    chk("ab_err_pre", bus.err_cnt, 'h1FF);
    bus.abort = 1'b1;
    bus.hold = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    bus.hold = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_done", bus.done, 0);
    chk("ab_err", bus.err_cnt, 'h1FF);
    chk("ab_pass", bus.pass, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("ab_quiet", seen, 0);

    // Asynchronous reset mid-run, no resume afterwards.
    start_sweep(5, 1'b0);
    wait_vec('h300, ok);
    chk("rs_reach300", ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_vec", bus.vec_out, 0);
    chk("rs_busy", bus.busy, 0);
    chk("rs_done", bus.done, 0);
    chk("rs_err", bus.err_cnt, 0);
    chk("rs_pass", bus.pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy || bus.done || bus.vec_out != 0) seen = 1'b1;
    end
    chk("rs_no_resume", seen, 0);

    // Random mismatch maps against a counting model.
    mode = 4;
    for (int r = 0; r < 3; r++) begin
      int dens;
      dens = $urandom_range(1, 15);
      exp = 0;
      for (int v = 0; v < NV; v++) begin
        mtab[v] = ($urandom_range(0, 15) < dens);
        if (mtab[v]) exp++;
      end
      thr = exp + $urandom_range(0, 4) - 2;
      if (thr < 0) thr = 0;
      hl = $urandom_range(0, 6);
      run_check($sformatf("rnd%0d", r), thr,
                $urandom_range(0, NV - 2), hl, r[0], exp,
                exp <= thr, NV + 1 + hl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
